conv_mac_stream: RTL and testbench

- Sequential, parametrised successor to the combinational 4x4 convolution-plus-ReLU block.
- Accepts one signed data/kernel pair per beat over a valid/ready stream and accumulates exactly TAPS products into one window result.
- Adds a bias, saturates to OUT_W, applies optional ReLU, and presents the result on a valid/ready output.
- Sits between the window-fetch logic and the feature-map writer; one instance serves any kernel size via TAPS.

---
 rtl/conv_mac_stream.sv | 194 +++++++++++++++++++
 tb/tb_conv_mac_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// conv_mac_stream: streaming signed multiply-accumulate for one convolution
// window. Each accepted beat contributes one data*kernel product; after TAPS
// beats the bias-seeded sum is saturated to OUT_W, optionally ReLU-clamped
// and held on a valid/ready output until the consumer takes it.
module conv_mac_stream #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 25,
    parameter int TAPS   = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(TAPS) + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     relu_en,
    input  logic signed [OUT_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] in_kernel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_result,
    output logic                     out_sat
);

    localparam int PROD_W = 2*DATA_W;
    // One guard bit above the wider of ACC_W / OUT_W so that a full-range
    // bias plus the worst-case product sum can never wrap.
    localparam int SUM_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam int CNT_W  = $clog2(TAPS) + 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                    state_q,      state_d;
    logic [CNT_W-1:0]          cnt_q,        cnt_d;
    logic signed [SUM_W-1:0]   acc_q,        acc_d;
    logic signed [PROD_W-1:0]  prod_q,       prod_d;
    logic                      prod_vld_q,   prod_vld_d;
    logic                      relu_q,       relu_d;
    logic                      in_ready_q,   in_ready_d;
    logic                      out_valid_q,  out_valid_d;
    logic signed [OUT_W-1:0]   out_result_q, out_result_d;
    logic                      out_sat_q,    out_sat_d;

    logic                      beat_s;
    logic signed [SUM_W-1:0]   addend_s;
    logic signed [SUM_W-1:0]   final_s;

    // Sign-extend a registered product to the accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Sign-extend the bias to the accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_bias(input logic signed [OUT_W-1:0] b);
        return {{(SUM_W-OUT_W){b[OUT_W-1]}}, b};
    endfunction

    // Clamp to the OUT_W range, then apply ReLU; returns {sat_flag, result}.
    // The value fits when all bits from the OUT_W sign bit upward agree.
    function automatic logic [OUT_W:0] sat_relu(input logic signed [SUM_W-1:0] v,
                                                input logic relu);
        logic [SUM_W-OUT_W:0] top;
        logic                 pos_ovf;
        logic                 neg_ovf;
        logic [OUT_W-1:0]     res;
        top     = v[SUM_W-1:OUT_W-1];
        pos_ovf = ~v[SUM_W-1] & (|top);
        neg_ovf =  v[SUM_W-1] & ~(&top);
        if (pos_ovf) begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = v[OUT_W-1:0];
        end
        if (relu && res[OUT_W-1]) begin
            res = '0;
        end else begin
            res = res;
        end
        return {pos_ovf | neg_ovf, res};
    endfunction

    assign beat_s   = in_valid & in_ready_q;
    assign addend_s = prod_vld_q ? sext_prod(prod_q) : '0;
    assign final_s  = acc_q + addend_s;

    // Next-state logic: window sequencing, product capture and accumulation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        prod_vld_d   = beat_s;
        relu_d       = relu_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_sat_d    = out_sat_q;

        if (beat_s) begin
            prod_d = in_data * in_kernel;
        end else begin
            prod_d = prod_q;
        end

        case (state_q)
            S_IDLE: begin
                if (beat_s) begin
                    relu_d  = relu_en;
                    acc_d   = sext_bias(bias);
                    cnt_d   = CNT_W'(1);
                    state_d = (TAPS == 1) ? S_DRAIN : S_ACC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                acc_d = final_s;
                if (beat_s) begin
                    if (cnt_q == LAST_TAP) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DRAIN: begin
                acc_d                     = final_s;
                {out_sat_d, out_result_d} = sat_relu(final_s, relu_q);
                out_valid_d               = 1'b1;
                state_d                   = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    acc_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                acc_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_ACC);
    end

    // State and output registers; reset clears any partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            relu_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            prod_vld_q   <= prod_vld_d;
            relu_q       <= relu_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_conv_mac_stream.sv
// Self-checking bench for conv_mac_stream: directed windows from the test
// plan plus randomized windows with input gaps and output stalls, checked
// against a plain-arithmetic window model.
module tb_conv_mac_stream;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 25;
    localparam int TAPS   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     relu_en;
    logic signed [OUT_W-1:0]  bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_kernel;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_result;
    logic                     out_sat;

    int n_chk  = 0;
    int n_pass = 0;
    int dq [TAPS];
    int kq [TAPS];

    conv_mac_stream #(.DATA_W(DATA_W), .OUT_W(OUT_W), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .relu_en    (relu_en),
        .bias       (bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_kernel  (in_kernel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sat    (out_sat)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int d, input int k);
        for (int i = 0; i < TAPS; i++) begin
            dq[i] = d;
            kq[i] = k;
        end
    endtask

    // Reference: bias + sum of products, clamp to OUT_W, then ReLU.
    task automatic model(input longint b, input bit relu, output longint r, output bit s);
        longint sum;
        longint maxv;
        longint minv;
        maxv = (longint'(1) << (OUT_W-1)) - 1;
        minv = -(longint'(1) << (OUT_W-1));
        sum = b;
        for (int i = 0; i < TAPS; i++) sum += longint'(dq[i]) * longint'(kq[i]);
        s = 1'b0;
        r = sum;
        if (sum > maxv) begin r = maxv; s = 1'b1; end
        if (sum < minv) begin r = minv; s = 1'b1; end
        if (relu && r < 0) r = 0;
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Drive one full window, then check latency, busy in_ready, result,
    // stability under output stall and the return to IDLE.
    task automatic run_window(input string tag, input longint b, input bit relu,
                              input int gap_pct, input int stall);
        longint er;
        bit     es;
        int     beat;
        int     guard;
        int     lat;
        bit     rdy;
        model(b, relu, er, es);
        out_ready = (stall == 0);
        beat  = 0;
        guard = 0;
        while (beat < TAPS && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid  = 1'b0;
                in_data   = DATA_W'(rnd8());
                in_kernel = DATA_W'(rnd8());
            end else begin
                in_valid  = 1'b1;
                in_data   = DATA_W'(dq[beat]);
                in_kernel = DATA_W'(kq[beat]);
            end
            if (beat == 0) begin
                relu_en = relu;
                bias    = b[OUT_W-1:0];
            end else begin
                relu_en = $urandom_range(1) != 0;
                bias    = OUT_W'($urandom);
            end
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) beat++;
        end
        chk({tag, "_beats"}, beat, TAPS);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = DATA_W'(rnd8());
            in_kernel = DATA_W'(rnd8());
            lat++;
            chk({tag, "_in_ready_busy"}, longint'(in_ready), 0);
        end while (!out_valid && lat < 20);
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_result"}, longint'(out_result), er);
        chk({tag, "_sat"}, longint'(out_sat), longint'(es));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk({tag, "_stall_valid"}, longint'(out_valid), 1);
                chk({tag, "_stall_result"}, longint'(out_result), er);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_valid_drop"}, longint'(out_valid), 0);
        chk({tag, "_idle_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint rb;
        rst       = 1'b1;
        relu_en   = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_kernel = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_result", longint'(out_result), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", longint'(in_ready), 1);

        fill(1, 1);     run_window("ones_relu", 0, 1'b1, 0, 0);
        fill(1, -1);    run_window("neg_relu", 0, 1'b1, 0, 0);
        fill(1, -1);    run_window("neg_norelu", 0, 1'b0, 0, 0);
        fill(1, -1);    run_window("neg_bias20", 20, 1'b0, 0, 0);
        fill(-128, -128); run_window("extreme", 0, 1'b0, 0, 0);
        fill(127, 127); run_window("sat_pos", (longint'(1) << (OUT_W-1)) - 1000, 1'b0, 0, 0);
        fill(-128, 127); run_window("sat_neg", -(longint'(1) << (OUT_W-1)) + 5, 1'b0, 0, 0);
        fill(-128, 127); run_window("sat_neg_relu", -(longint'(1) << (OUT_W-1)) + 5, 1'b1, 0, 0);
        fill(1, 1);     run_window("gaps_stall", 7, 1'b0, 40, 10);

        // Abort a window after 7 beats with a reset, then restart cleanly.
        fill(5, 5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = DATA_W'(dq[i]);
            in_kernel = DATA_W'(kq[i]);
            bias      = OUT_W'(100);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill(1, 1);     run_window("after_rst", 0, 1'b0, 0, 0);

        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < TAPS; i++) begin
                dq[i] = rnd8();
                kq[i] = rnd8();
            end
            if (w % 4 == 3) rb = (longint'($urandom_range(1)) == 0) ?
                                 (longint'(1) << (OUT_W-1)) - 1 : -(longint'(1) << (OUT_W-1));
            else rb = longint'($urandom_range(2000000)) - 1000000;
            run_window("rand", rb, $urandom_range(1) != 0, 30, int'($urandom_range(6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
